// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam logic [7:0] SPI_CMD_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_STAT,
        ST_IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins and byte-fetch memory port of the flash responder.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_clk_i;
    logic              spi_cs_n_i;
    logic              spi_sdat_i;
    logic              spi_sdat_o;
    logic              spi_sdat_oe;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport slave (
        input  spi_clk_i, spi_cs_n_i, spi_sdat_i, mem_ack, mem_rdata,
        output spi_sdat_o, spi_sdat_oe, mem_req, mem_addr
    );

    modport master (
        output spi_clk_i, spi_cs_n_i, spi_sdat_i, mem_ack, mem_rdata,
        input  spi_sdat_o, spi_sdat_oe, mem_req, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder_sync.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses off the last stage.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sr;
    logic              q_d;

    // Chain resets low so a cs_n held low through reset never produces a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            q_d <= 1'b0;
        end else begin
            sr  <= {sr[STAGES-2:0], d};
            q_d <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: READ/RDSR decode, one-byte prefetch buffer, MSB-first MISO.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int         ADDR_W      = 24,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] STATUS_VAL  = 8'h00
) (
    input  logic                  ext_clk,
    input  logic                  ext_rst,
    spi_flash_responder_if.slave  bus,
    output logic                  busy,
    output logic                  err_unsup,
    output logic                  err_underrun
);
    localparam int             ABW       = $clog2(ADDR_W);
    localparam logic [ABW-1:0] ADDR_LAST = ABW'(ADDR_W - 1);

    logic unused_clk_level, unused_sdat_rise, unused_sdat_fall;
    logic clk_rise, clk_fall, cs_q, cs_rise, cs_fall, sdat_q;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(ext_clk), .rst(ext_rst), .d(bus.spi_clk_i),
        .q(unused_clk_level), .rise(clk_rise), .fall(clk_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(ext_clk), .rst(ext_rst), .d(bus.spi_cs_n_i),
        .q(cs_q), .rise(cs_rise), .fall(cs_fall));
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sdat (
        .clk(ext_clk), .rst(ext_rst), .d(bus.spi_sdat_i),
        .q(sdat_q), .rise(unused_sdat_rise), .fall(unused_sdat_fall));

    spi_state_e        state;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [ADDR_W-1:0] addr_q;
    logic [ABW-1:0]    addr_bits;
    logic [7:0]        byte_buf;
    logic              buf_vld;
    logic              sdat_o_q, oe_q, req_q;
    logic              fetch_hit;
    logic [7:0]        next_byte;

    // An ack landing on the boundary cycle feeds the shifter directly.
    assign fetch_hit = req_q & bus.mem_ack;
    assign next_byte = buf_vld ? byte_buf : (fetch_hit ? bus.mem_rdata : 8'hFF);

    always_ff @(posedge ext_clk) begin
        if (ext_rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            addr_q       <= '0;
            addr_bits    <= '0;
            byte_buf     <= '0;
            buf_vld      <= 1'b0;
            sdat_o_q     <= 1'b0;
            oe_q         <= 1'b0;
            req_q        <= 1'b0;
            err_unsup    <= 1'b0;
            err_underrun <= 1'b0;
        end else if (cs_rise) begin
            state   <= ST_IDLE;
            oe_q    <= 1'b0;
            req_q   <= 1'b0;
            buf_vld <= 1'b0;
        end else begin
            if (clk_rise) begin
                rx_sr   <= {rx_sr[5:0], sdat_q};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (clk_fall) begin
                sdat_o_q <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b0};
            end
            case (state)
                ST_IDLE: if (cs_fall) begin
                    state   <= ST_CMD;
                    bit_cnt <= '0;
                end
                ST_CMD: if (clk_rise && bit_cnt == 3'd7) begin
                    case ({rx_sr, sdat_q})
                        SPI_CMD_READ: begin
                            state     <= ST_ADDR;
                            addr_bits <= '0;
                        end
                        SPI_CMD_RDSR: begin
                            state <= ST_STAT;
                            oe_q  <= 1'b1;
                            tx_sr <= STATUS_VAL;
                        end
                        default: begin
                            state     <= ST_IGNORE;
                            err_unsup <= 1'b1;
                        end
                    endcase
                end
                ST_ADDR: if (clk_rise) begin
                    addr_q    <= {addr_q[ADDR_W-2:0], sdat_q};
                    addr_bits <= addr_bits + 1'b1;
                    if (addr_bits == ADDR_LAST) begin
                        state   <= ST_DATA;
                        oe_q    <= 1'b1;
                        req_q   <= 1'b1;
                        buf_vld <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fetch_hit) begin
                        byte_buf <= bus.mem_rdata;
                        buf_vld  <= 1'b1;
                        req_q    <= 1'b0;
                    end
                    // Byte boundary; an unfinished fetch is retargeted to the next address.
                    if (clk_fall && bit_cnt == 3'd0) begin
                        sdat_o_q <= next_byte[7];
                        tx_sr    <= {next_byte[6:0], 1'b0};
                        buf_vld  <= 1'b0;
                        addr_q   <= addr_q + ADDR_W'(1);
                        req_q    <= 1'b1;
                        if (!buf_vld && !fetch_hit)
                            err_underrun <= 1'b1;
                    end
                end
                ST_STAT: if (clk_fall && bit_cnt == 3'd0) begin
                    sdat_o_q <= STATUS_VAL[7];
                    tx_sr    <= {STATUS_VAL[6:0], 1'b0};
                end
                ST_IGNORE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = ~cs_q & (state != ST_IDLE);
    assign bus.spi_sdat_o  = sdat_o_q;
    assign bus.spi_sdat_oe = oe_q;
    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
endmodule
